predict_hls_axis_block_detector: RTL and testbench

// - Producer of the per-channel axis block vector that the deadlock monitors consume.
// - Watches NUM_CH AXI-Stream handshakes of an HLS instance.
// - Flags a channel as blocked once it has stalled for THRESH consecutive cycles.
// - Latches the first blocked channel into a one-shot debug report with a valid/ack handshake.

---
 rtl/predict_hls_dbg_pkg.sv | 23 ++
 rtl/predict_hls_stall_counter.sv | 47 ++++
 rtl/predict_hls_axis_block_detector.sv | 84 ++++++++
 tb/tb_predict_hls_axis_block_detector.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/predict_hls_dbg_pkg.sv
// Shared types and helpers for the HLS AXIS block detector and its report FSM.
package predict_hls_dbg_pkg;

  typedef enum logic [1:0] {ARMED, REPORT, HOLD} rpt_state_e;

  localparam int unsigned STAMP_W = 32;
  localparam int unsigned MAX_CH  = 64;

  function automatic int unsigned lowest_set_idx(input logic [MAX_CH-1:0] vec);
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if (vec[i] && !found) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/predict_hls_stall_counter.sv
// One AXIS channel: stall detection, saturating stall counter and registered blocked flag.
module predict_hls_stall_counter #(
  parameter int unsigned CNT_W   = 16,
  parameter bit          IS_READ = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] thresh_i,
  input  logic             tvalid_i,
  input  logic             tready_i,
  output logic             block_d_o,
  output logic             block_q_o
);

  logic             stall;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W:0]   thr_eff;
  logic             block_d, block_q;

  always_comb begin
    stall   = IS_READ ? (tready_i & ~tvalid_i) : (tvalid_i & ~tready_i);
    cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
    // Threshold 0 behaves as 1; compare one bit wider so all-ones count still matches.
    thr_eff = (thresh_i == '0) ? (CNT_W+1)'(1) : {1'b0, thresh_i};
    block_d = enable_i & stall & (cnt_inc >= thr_eff);
    cnt_d   = '0;
    if (enable_i && stall) begin
      cnt_d = (&cnt_q) ? cnt_q : cnt_inc[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      block_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      block_q <= block_d;
    end
  end

  assign block_d_o = block_d;
  assign block_q_o = block_q;

endmodule

// File: rtl/predict_hls_axis_block_detector.sv
// Per-channel AXIS blocked vector plus a one-shot first-block debug report with valid/ack.
module predict_hls_axis_block_detector
  import predict_hls_dbg_pkg::*;
#(
  parameter int unsigned        NUM_CH  = 2,
  parameter int unsigned        CNT_W   = 16,
  parameter logic [NUM_CH-1:0]  IS_READ = NUM_CH'(2'b01),
  localparam int unsigned       RPT_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [CNT_W-1:0]   thresh,
  input  logic [NUM_CH-1:0]  ch_tvalid,
  input  logic [NUM_CH-1:0]  ch_tready,
  output logic [NUM_CH-1:0]  axis_block_sigs,
  output logic               rpt_valid,
  output logic [RPT_W-1:0]   rpt_ch,
  output logic [STAMP_W-1:0] rpt_cycles,
  input  logic               rpt_ack
);

  logic [NUM_CH-1:0]  block_d, block_q;
  logic [STAMP_W-1:0] stamp_q;
  rpt_state_e         state_q;
  logic               rpt_valid_q;
  logic [RPT_W-1:0]   rpt_ch_q;
  logic [STAMP_W-1:0] rpt_cycles_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    predict_hls_stall_counter #(
      .CNT_W   (CNT_W),
      .IS_READ (IS_READ[g])
    ) u_cnt (
      .clock     (clock),
      .reset     (reset),
      .enable_i  (enable),
      .thresh_i  (thresh),
      .tvalid_i  (ch_tvalid[g]),
      .tready_i  (ch_tready[g]),
      .block_d_o (block_d[g]),
      .block_q_o (block_q[g])
    );
  end

  // Capture uses next-state flags so the report lands on the same edge the flag rises.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ARMED;
      rpt_valid_q  <= 1'b0;
      rpt_ch_q     <= '0;
      rpt_cycles_q <= '0;
      stamp_q      <= '0;
    end else begin
      stamp_q <= stamp_q + STAMP_W'(1);
      case (state_q)
        ARMED: begin
          if (|block_d) begin
            rpt_ch_q     <= RPT_W'(lowest_set_idx(MAX_CH'(block_d)));
            rpt_cycles_q <= stamp_q;
            rpt_valid_q  <= 1'b1;
            state_q      <= REPORT;
          end
        end
        REPORT: begin
          if (rpt_ack) begin
            rpt_valid_q <= 1'b0;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (block_q == '0) state_q <= ARMED;
        end
        default: state_q <= ARMED;
      endcase
    end
  end

  assign axis_block_sigs = block_q;
  assign rpt_valid       = rpt_valid_q;
  assign rpt_ch          = rpt_ch_q;
  assign rpt_cycles      = rpt_cycles_q;

endmodule

// File: tb/tb_predict_hls_axis_block_detector.sv
// Directed self-checking bench for the AXIS block detector (default and CNT_W=4 instances).
module tb_predict_hls_axis_block_detector;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] thresh;
  logic [3:0]  thresh4;
  logic [1:0]  tvalid, tready;
  logic        ack;
  logic [1:0]  blk;
  logic        rv;
  logic        rch;
  logic [31:0] rcy;
  logic [1:0]  blk2;
  logic        rv2;
  logic        rch2;
  logic [31:0] rcy2;
  logic [31:0] tb_stamp;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) tb_stamp <= 32'd0;
    else       tb_stamp <= tb_stamp + 32'd1;
  end

  predict_hls_axis_block_detector #(.NUM_CH(2), .CNT_W(16), .IS_READ(2'b01)) dut (
    .clock(clock), .reset(reset), .enable(enable), .thresh(thresh),
    .ch_tvalid(tvalid), .ch_tready(tready), .axis_block_sigs(blk),
    .rpt_valid(rv), .rpt_ch(rch), .rpt_cycles(rcy), .rpt_ack(ack)
  );

  predict_hls_axis_block_detector #(.NUM_CH(2), .CNT_W(4), .IS_READ(2'b01)) dut4 (
    .clock(clock), .reset(reset), .enable(enable), .thresh(thresh4),
    .ch_tvalid(tvalid), .ch_tready(tready), .axis_block_sigs(blk2),
    .rpt_valid(rv2), .rpt_ch(rch2), .rpt_cycles(rcy2), .rpt_ack(ack)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ch0 is a read port (stall = tready & ~tvalid), ch1 a write port (stall = tvalid & ~tready).
  task automatic drive_stall(input logic [1:0] m);
    tvalid = {m[1], 1'b0};
    tready = {1'b0, m[0]};
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; thresh = 16'd4; thresh4 = 4'd15;
    tvalid = 2'b00; tready = 2'b00; ack = 1'b0;
    tick(); tick();
    n_cmp++; if (blk !== 2'b00) begin $display("FAIL reset_blk got=%b exp=00", blk); n_bad++; end
    n_cmp++; if (rv !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", rv); n_bad++; end
    n_cmp++; if (rch !== 1'b0) begin $display("FAIL reset_ch got=%b exp=0", rch); n_bad++; end
    n_cmp++; if (rcy !== 32'd0) begin $display("FAIL reset_cycles got=%0d exp=0", rcy); n_bad++; end
    reset = 1'b0;
  endtask

  task automatic test_write_block();
    logic [31:0] exp_stamp;
    logic [1:0]  exp_blk;
    exp_stamp = '0;
    thresh = 16'd4;
    drive_stall(2'b10);
    for (int k = 1; k <= 6; k++) begin
      if (k == 4) exp_stamp = tb_stamp;
      tick();
      exp_blk = (k >= 4) ? 2'b10 : 2'b00;
      n_cmp++; if (blk !== exp_blk) begin $display("FAIL wr_blk k=%0d got=%b exp=%b", k, blk, exp_blk); n_bad++; end
      n_cmp++; if (rv !== (k >= 4)) begin $display("FAIL wr_valid k=%0d got=%b exp=%b", k, rv, (k >= 4)); n_bad++; end
    end
    n_cmp++; if (rch !== 1'b1) begin $display("FAIL wr_ch got=%b exp=1", rch); n_bad++; end
    n_cmp++; if (rcy !== exp_stamp) begin $display("FAIL wr_cycles got=%0d exp=%0d", rcy, exp_stamp); n_bad++; end
    drive_stall(2'b00);
    tick();
    n_cmp++; if (blk !== 2'b00) begin $display("FAIL wr_release got=%b exp=00", blk); n_bad++; end
    n_cmp++; if (rv !== 1'b1) begin $display("FAIL wr_valid_kept got=%b exp=1", rv); n_bad++; end
    n_cmp++; if (rcy !== exp_stamp) begin $display("FAIL wr_cycles_stable got=%0d exp=%0d", rcy, exp_stamp); n_bad++; end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_cmp++; if (rv !== 1'b0) begin $display("FAIL wr_ack got=%b exp=0", rv); n_bad++; end
    tick();
  endtask

  task automatic test_interrupted_stall();
    thresh = 16'd4;
    for (int k = 0; k < 7; k++) begin
      if (k == 3) begin tvalid = 2'b10; tready = 2'b10; end
      else drive_stall(2'b10);
      tick();
      n_cmp++; if (blk !== 2'b00) begin $display("FAIL intr_blk k=%0d got=%b exp=00", k, blk); n_bad++; end
      n_cmp++; if (rv !== 1'b0) begin $display("FAIL intr_valid k=%0d got=%b exp=0", k, rv); n_bad++; end
    end
    drive_stall(2'b00);
    tick();
  endtask

  task automatic test_simultaneous();
    thresh = 16'd4;
    drive_stall(2'b11);
    for (int k = 1; k <= 4; k++) tick();
    n_cmp++; if (blk !== 2'b11) begin $display("FAIL sim_blk got=%b exp=11", blk); n_bad++; end
    n_cmp++; if (rv !== 1'b1) begin $display("FAIL sim_valid got=%b exp=1", rv); n_bad++; end
    n_cmp++; if (rch !== 1'b0) begin $display("FAIL sim_ch got=%b exp=0", rch); n_bad++; end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick(); tick();
    n_cmp++; if (rv !== 1'b0) begin $display("FAIL sim_hold_valid got=%b exp=0", rv); n_bad++; end
    drive_stall(2'b00);
    tick();
    n_cmp++; if (blk !== 2'b00) begin $display("FAIL sim_release got=%b exp=00", blk); n_bad++; end
    drive_stall(2'b10);
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if (rv !== (k == 4)) begin $display("FAIL rearm_valid k=%0d got=%b exp=%b", k, rv, (k == 4)); n_bad++; end
    end
    n_cmp++; if (rch !== 1'b1) begin $display("FAIL rearm_ch got=%b exp=1", rch); n_bad++; end
    drive_stall(2'b00);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick(); tick();
  endtask

  task automatic test_thresh_zero();
    thresh = 16'd0;
    drive_stall(2'b10);
    tick();
    n_cmp++; if (blk !== 2'b10) begin $display("FAIL t0_blk got=%b exp=10", blk); n_bad++; end
    n_cmp++; if (rv !== 1'b1) begin $display("FAIL t0_valid got=%b exp=1", rv); n_bad++; end
    drive_stall(2'b00);
    tick();
    n_cmp++; if (blk !== 2'b00) begin $display("FAIL t0_release got=%b exp=00", blk); n_bad++; end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
  endtask

  task automatic test_enable();
    thresh = 16'd4;
    drive_stall(2'b10);
    for (int k = 1; k <= 4; k++) tick();
    n_cmp++; if (rv !== 1'b1) begin $display("FAIL en_valid_pre got=%b exp=1", rv); n_bad++; end
    enable = 1'b0;
    tick();
    n_cmp++; if (blk !== 2'b00) begin $display("FAIL en_blk_off got=%b exp=00", blk); n_bad++; end
    n_cmp++; if (rv !== 1'b1) begin $display("FAIL en_valid_kept got=%b exp=1", rv); n_bad++; end
    enable = 1'b1;
    tick();
    n_cmp++; if (blk !== 2'b00) begin $display("FAIL en_count_cleared got=%b exp=00", blk); n_bad++; end
    drive_stall(2'b00);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick(); tick();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_blk;
    thresh = 16'hFFFF;
    thresh4 = 4'd15;
    drive_stall(2'b10);
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp_blk = (k >= 15) ? 2'b10 : 2'b00;
      n_cmp++; if (blk2 !== exp_blk) begin $display("FAIL sat_blk k=%0d got=%b exp=%b", k, blk2, exp_blk); n_bad++; end
      if (k == 15) begin
        n_cmp++; if (rv2 !== 1'b1) begin $display("FAIL sat_valid got=%b exp=1", rv2); n_bad++; end
        n_cmp++; if (rch2 !== 1'b1) begin $display("FAIL sat_ch got=%b exp=1", rch2); n_bad++; end
      end
    end
    n_cmp++; if (blk !== 2'b00) begin $display("FAIL sat_main_blk got=%b exp=00", blk); n_bad++; end
    drive_stall(2'b00);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick(); tick();
    thresh = 16'd4;
  endtask

  task automatic test_reset_during_report();
    thresh = 16'd4;
    drive_stall(2'b10);
    for (int k = 1; k <= 4; k++) tick();
    n_cmp++; if (rv !== 1'b1) begin $display("FAIL rst_pre_valid got=%b exp=1", rv); n_bad++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (rv !== 1'b0) begin $display("FAIL rst_valid got=%b exp=0", rv); n_bad++; end
    n_cmp++; if (blk !== 2'b00) begin $display("FAIL rst_blk got=%b exp=00", blk); n_bad++; end
    n_cmp++; if (rcy !== 32'd0) begin $display("FAIL rst_cycles got=%0d exp=0", rcy); n_bad++; end
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if (blk[1] !== (k == 4)) begin $display("FAIL rst_recount k=%0d got=%b exp=%b", k, blk[1], (k == 4)); n_bad++; end
    end
    n_cmp++; if (rv !== 1'b1) begin $display("FAIL rst_new_report got=%b exp=1", rv); n_bad++; end
    drive_stall(2'b00);
    tick();
  endtask

  initial begin
    test_reset();
    test_write_block();
    test_interrupted_stall();
    test_simultaneous();
    test_thresh_zero();
    test_enable();
    test_saturation();
    test_reset_during_report();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
